mmc64_dma: RTL and testbench

//  SD/MMC SPI host register block with bidirectional block DMA. Extends the MMC64-style

---
 rtl/mmc64_dma.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_mmc64_dma.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc64_dma.sv
// mmc64_dma: MMC64-style SD/MMC SPI host register file with a block DMA engine.
// Block reads move data card->RAM and block writes move RAM->card. The block
// length, the poll timeout and the last CRC and data-response bytes are visible
// through the register file.
//
// Ports:
//   clk, reset            system clock; synchronous active-high reset
//   a, d_d, d_q           register select, bus write data, registered read data
//   read_strobe           one-cycle register read
//   write_strobe          one-cycle register write
//   spi_d, spi_q          byte to send to the card, byte received from it
//   spi_req, spi_ack      toggle handshake; a transfer is pending while they differ
//   spi_speed, spi_cs     SPI clock select, card chip select (active low)
//   wp, cd, exrom, game   status inputs
//   disable_exrom         control register bit 5
//   ram_a, ram_d, ram_q   DMA address, write data (last rx byte), read data
//   ram_we                1 = write to RAM (card->RAM), 0 = read from RAM
//   ram_req, ram_ack      toggle handshake, same rule as the SPI pair
module mmc64_dma #(
    parameter int RAM_A_BITS = 17,
    parameter int BLK_LOG2   = 9,
    parameter int POLL_LIMIT = 4095
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            a,
    input  logic [7:0]            d_d,
    output logic [7:0]            d_q,
    input  logic                  read_strobe,
    input  logic                  write_strobe,
    output logic [7:0]            spi_d,
    input  logic [7:0]            spi_q,
    output logic                  spi_req,
    input  logic                  spi_ack,
    output logic                  spi_speed,
    output logic                  spi_cs,
    input  logic                  wp,
    input  logic                  cd,
    input  logic                  exrom,
    input  logic                  game,
    output logic                  disable_exrom,
    output logic [RAM_A_BITS-1:0] ram_a,
    output logic [7:0]            ram_d,
    input  logic [7:0]            ram_q,
    output logic                  ram_we,
    output logic                  ram_req,
    input  logic                  ram_ack
);

    localparam logic [11:0] POLL_MAX = 12'(POLL_LIMIT);

    typedef enum logic [3:0] {
        IDLE, R_TOK, R_DAT, R_INC, R_CRC,
        W_GAP, W_TOK, W_RD, W_SND, W_CRC, W_RSP, W_BSY
    } state_t;

    state_t              state_q, state_d;
    logic                ph_q, ph_d;           // second half of a two-step state
    logic [7:0]          rdata_q, rdata_d;
    logic [7:0]          tx_q, tx_d;
    logic [7:0]          rx_q, rx_d;
    logic                ack_q, ack_d;
    logic                spi_req_q, spi_req_d;
    logic                ram_req_q, ram_req_d;
    logic                ram_we_q, ram_we_d;
    logic                cs_q, cs_d;
    logic                speed_q, speed_d;
    logic                exdis_q, exdis_d;
    logic                active_q, active_d;
    logic                trigger_q, trigger_d;
    logic [23:0]         ptr_q, ptr_d;
    logic [7:0]          blkcnt_q, blkcnt_d;
    logic [BLK_LOG2-1:0] bytecnt_q, bytecnt_d;
    logic [11:0]         poll_q, poll_d;
    logic                rd_fail_q, rd_fail_d;
    logic                wr_fail_q, wr_fail_d;
    logic                timeout_q, timeout_d;
    logic [7:0]          crc_lo_q, crc_lo_d;
    logic [7:0]          crc_hi_q, crc_hi_d;
    logic [7:0]          resp_q, resp_d;

    logic       busy, rd_busy, wr_busy, spi_busy, spi_idle, ram_idle, step, reg_wr3;
    logic       send_en, blk_end;
    logic [7:0] send_byte;
    logic [11:0] poll_inc;

    assign d_q           = rdata_q;
    assign spi_d         = tx_q;
    assign spi_req       = spi_req_q;
    assign spi_speed     = speed_q;
    assign spi_cs        = cs_q;
    assign disable_exrom = exdis_q;
    assign ram_a         = ptr_q[RAM_A_BITS-1:0];
    assign ram_d         = rx_q;
    assign ram_we        = ram_we_q;
    assign ram_req       = ram_req_q;

    assign rd_busy  = state_q inside {R_TOK, R_DAT, R_INC, R_CRC};
    assign wr_busy  = state_q inside {W_GAP, W_TOK, W_RD, W_SND, W_CRC, W_RSP, W_BSY};
    assign busy     = rd_busy | wr_busy;
    assign spi_busy = spi_req_q != spi_ack;
    // rx_q only holds the reply one cycle after the ack edge, so wait for ack_q too.
    assign spi_idle = (spi_req_q == spi_ack) && (ack_q == spi_ack);
    assign ram_idle = ram_req_q == ram_ack;
    assign reg_wr3  = write_strobe && (a == 4'h3);
    // A command-register write in the same cycle pre-empts the engine step.
    assign step     = busy && spi_idle && ram_idle && !reg_wr3;
    assign poll_inc = poll_q + 12'd1;

    always_comb begin
        state_d   = state_q;   ph_d      = ph_q;      rdata_d   = rdata_q;
        tx_d      = tx_q;      rx_d      = rx_q;      ack_d     = ack_q;
        spi_req_d = spi_req_q; ram_req_d = ram_req_q; ram_we_d  = ram_we_q;
        cs_d      = cs_q;      speed_d   = speed_q;   exdis_d   = exdis_q;
        active_d  = active_q;  trigger_d = trigger_q; ptr_d     = ptr_q;
        blkcnt_d  = blkcnt_q;  bytecnt_d = bytecnt_q; poll_d    = poll_q;
        rd_fail_d = rd_fail_q; wr_fail_d = wr_fail_q; timeout_d = timeout_q;
        crc_lo_d  = crc_lo_q;  crc_hi_d  = crc_hi_q;  resp_d    = resp_q;
        send_en   = 1'b0;      send_byte = 8'hFF;     blk_end   = 1'b0;

        if (spi_ack != ack_q) begin
            rx_d  = spi_q;
            ack_d = spi_ack;
        end

        if (step) begin
            case (state_q)
                R_TOK: begin
                    if (!ph_q) begin
                        send_en = 1'b1;
                        ph_d    = 1'b1;
                    end else if (rx_q == 8'hFE) begin
                        send_en   = 1'b1;
                        bytecnt_d = '1;
                        state_d   = R_DAT;
                    end else if (rx_q == 8'hFF) begin
                        if (poll_inc == POLL_MAX) begin
                            timeout_d = 1'b1;
                            rd_fail_d = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            poll_d  = poll_inc;
                            send_en = 1'b1;
                        end
                    end else begin
                        rd_fail_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
                R_DAT: begin
                    ram_we_d  = 1'b1;
                    ram_req_d = ~ram_req_q;
                    state_d   = R_INC;
                end
                R_INC: begin
                    ptr_d   = ptr_q + 24'd1;
                    send_en = 1'b1;
                    if (bytecnt_q == '0) begin
                        state_d = R_CRC;
                        ph_d    = 1'b0;
                    end else begin
                        bytecnt_d = bytecnt_q - 1'b1;
                        state_d   = R_DAT;
                    end
                end
                R_CRC: begin
                    // Card sends the CRC high byte first.
                    if (!ph_q) begin
                        crc_hi_d = rx_q;
                        send_en  = 1'b1;
                        ph_d     = 1'b1;
                    end else begin
                        crc_lo_d = rx_q;
                        blk_end  = 1'b1;
                    end
                end
                W_GAP: begin
                    send_en = 1'b1;
                    state_d = W_TOK;
                end
                W_TOK: begin
                    send_en   = 1'b1;
                    send_byte = 8'hFE;
                    bytecnt_d = '1;
                    state_d   = W_RD;
                end
                W_RD: begin
                    ram_we_d  = 1'b0;
                    ram_req_d = ~ram_req_q;
                    state_d   = W_SND;
                end
                W_SND: begin
                    send_en   = 1'b1;
                    send_byte = ram_q;
                    ptr_d     = ptr_q + 24'd1;
                    if (bytecnt_q == '0) begin
                        state_d = W_CRC;
                        ph_d    = 1'b0;
                    end else begin
                        bytecnt_d = bytecnt_q - 1'b1;
                        state_d   = W_RD;
                    end
                end
                W_CRC: begin
                    // Dummy CRC: two FF bytes.
                    send_en = 1'b1;
                    ph_d    = ~ph_q;
                    if (ph_q) state_d = W_RSP;
                end
                W_RSP: begin
                    if (!ph_q) begin
                        send_en = 1'b1;
                        ph_d    = 1'b1;
                    end else begin
                        resp_d = rx_q;
                        ph_d   = 1'b0;
                        if (rx_q[4:0] == 5'h05) begin
                            poll_d  = '0;
                            state_d = W_BSY;
                        end else begin
                            wr_fail_d = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end
                W_BSY: begin
                    if (!ph_q) begin
                        send_en = 1'b1;
                        ph_d    = 1'b1;
                    end else if (rx_q == 8'hFF) begin
                        blk_end = 1'b1;
                    end else if (poll_inc == POLL_MAX) begin
                        timeout_d = 1'b1;
                        wr_fail_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        poll_d  = poll_inc;
                        send_en = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // blkcnt 0 wraps to FF, i.e. a 256-block transfer.
        if (blk_end) begin
            blkcnt_d = blkcnt_q - 8'd1;
            poll_d   = '0;
            ph_d     = 1'b0;
            if (blkcnt_q == 8'd1) state_d = IDLE;
            else                  state_d = rd_busy ? R_TOK : W_GAP;
        end

        if (read_strobe) begin
            case (a)
                4'h0: rdata_d = rx_q;
                4'h1: rdata_d = {active_q, trigger_q, exdis_q, 2'b00, speed_q, cs_q, 1'b1};
                4'h2: rdata_d = {3'b000, wp, cd, exrom, game, spi_busy};
                4'h3: rdata_d = {3'b000, timeout_q, wr_fail_q, rd_fail_q, wr_busy, rd_busy};
                4'h4: rdata_d = blkcnt_q;
                4'h5: rdata_d = ptr_q[7:0];
                4'h6: rdata_d = ptr_q[15:8];
                4'h7: rdata_d = ptr_q[23:16];
                4'h8: rdata_d = crc_lo_q;
                4'h9: rdata_d = crc_hi_q;
                4'hA: rdata_d = resp_q;
                default: rdata_d = 8'hFF;
            endcase
            if (a == 4'h0 && !busy && !active_q && trigger_q) send_en = 1'b1;
        end

        if (write_strobe) begin
            case (a)
                4'h0: if (!busy) begin
                    if (!active_q && !trigger_q) begin
                        send_en   = 1'b1;
                        send_byte = d_d;
                    end else begin
                        tx_d = d_d;
                    end
                end
                4'h1: begin
                    active_d  = d_d[7];
                    trigger_d = d_d[6];
                    exdis_d   = d_d[5];
                    speed_d   = d_d[2];
                    cs_d      = d_d[1];
                end
                4'h3: begin
                    if (!busy && (d_d[0] || d_d[1])) begin
                        state_d   = d_d[0] ? R_TOK : W_GAP;
                        ph_d      = 1'b0;
                        poll_d    = '0;
                        rd_fail_d = 1'b0;
                        wr_fail_d = 1'b0;
                        timeout_d = 1'b0;
                    end else if (busy && d_d[1:0] == 2'b00) begin
                        state_d   = IDLE;
                        rd_fail_d = rd_fail_q | rd_busy;
                        wr_fail_d = wr_fail_q | wr_busy;
                    end
                end
                4'h4: if (!busy) blkcnt_d = d_d;
                4'h5: if (!busy) ptr_d[7:0]   = d_d;
                4'h6: if (!busy) ptr_d[15:8]  = d_d;
                4'h7: if (!busy) ptr_d[23:16] = d_d;
                default: ;
            endcase
        end

        if (send_en) begin
            tx_d      = send_byte;
            spi_req_d = ~spi_req_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;     ph_q      <= 1'b0;     rdata_q   <= 8'hFF;
            tx_q      <= 8'hFF;    rx_q      <= 8'hFF;    ack_q     <= spi_ack;
            spi_req_q <= spi_ack;  ram_req_q <= ram_ack;  ram_we_q  <= 1'b1;
            cs_q      <= 1'b1;     speed_q   <= 1'b0;     exdis_q   <= 1'b0;
            active_q  <= 1'b0;     trigger_q <= 1'b0;     ptr_q     <= '0;
            blkcnt_q  <= '0;       bytecnt_q <= '0;       poll_q    <= '0;
            rd_fail_q <= 1'b0;     wr_fail_q <= 1'b0;     timeout_q <= 1'b0;
            crc_lo_q  <= '0;       crc_hi_q  <= '0;       resp_q    <= '0;
        end else begin
            state_q   <= state_d;   ph_q      <= ph_d;      rdata_q   <= rdata_d;
            tx_q      <= tx_d;      rx_q      <= rx_d;      ack_q     <= ack_d;
            spi_req_q <= spi_req_d; ram_req_q <= ram_req_d; ram_we_q  <= ram_we_d;
            cs_q      <= cs_d;      speed_q   <= speed_d;   exdis_q   <= exdis_d;
            active_q  <= active_d;  trigger_q <= trigger_d; ptr_q     <= ptr_d;
            blkcnt_q  <= blkcnt_d;  bytecnt_q <= bytecnt_d; poll_q    <= poll_d;
            rd_fail_q <= rd_fail_d; wr_fail_q <= wr_fail_d; timeout_q <= timeout_d;
            crc_lo_q  <= crc_lo_d;  crc_hi_q  <= crc_hi_d;  resp_q    <= resp_d;
        end
    end

endmodule

// File: tb/tb_mmc64_dma.sv
// Scoreboard bench for mmc64_dma: card and RAM behavioural models answer the
// DUT handshakes; expected register reads, SPI tx bytes and RAM writes are
// queued by the stimulus and checked by monitor processes as they occur.
module tb_mmc64_dma;
    localparam int RAB = 17;
    localparam int BL  = 9;
    localparam int PL  = 16;
    localparam int NB  = 1 << BL;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [3:0]     a = '0;
    logic [7:0]     d_d = '0;
    logic [7:0]     d_q;
    logic           read_strobe = 1'b0;
    logic           write_strobe = 1'b0;
    logic [7:0]     spi_d;
    logic [7:0]     spi_q = 8'hFF;
    logic           spi_req;
    logic           spi_ack = 1'b0;
    logic           spi_speed, spi_cs, disable_exrom;
    logic           wp = 1'b1, cd = 1'b0, exrom = 1'b1, game = 1'b0;
    logic [RAB-1:0] ram_a;
    logic [7:0]     ram_d;
    logic [7:0]     ram_q = '0;
    logic           ram_we, ram_req;
    logic           ram_ack = 1'b0;

    mmc64_dma #(.RAM_A_BITS(RAB), .BLK_LOG2(BL), .POLL_LIMIT(PL)) dut (
        .clk(clk), .reset(reset), .a(a), .d_d(d_d), .d_q(d_q),
        .read_strobe(read_strobe), .write_strobe(write_strobe),
        .spi_d(spi_d), .spi_q(spi_q), .spi_req(spi_req), .spi_ack(spi_ack),
        .spi_speed(spi_speed), .spi_cs(spi_cs),
        .wp(wp), .cd(cd), .exrom(exrom), .game(game), .disable_exrom(disable_exrom),
        .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q), .ram_we(ram_we),
        .ram_req(ram_req), .ram_ack(ram_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [3:0] ad; logic [7:0] v; } rd_t;
    typedef struct packed { logic [RAB-1:0] addr; logic [7:0] data; } ramw_t;

    logic [7:0] mem [0:(1<<RAB)-1];
    logic [7:0] card_q[$];
    logic [7:0] exp_spi[$];
    rd_t        exp_rd[$];
    ramw_t      exp_ram[$];
    int checks = 0, failures = 0, spi_sends = 0, ram_reqs = 0;
    logic       rd_seen = 1'b0;
    logic [7:0] e_spi;
    rd_t        e_rd;
    ramw_t      e_ram;

    // Card model: answers each pending transfer on the next falling edge.
    always @(negedge clk) begin
        if (!reset && spi_req != spi_ack) begin
            spi_sends++;
            if (exp_spi.size() > 0) begin
                e_spi = exp_spi.pop_front();
                checks++;
                if (spi_d !== e_spi) begin
                    failures++;
                    $display("FAIL spi_tx #%0d got %02h want %02h", spi_sends, spi_d, e_spi);
                end
            end
            spi_q   = (card_q.size() > 0) ? card_q.pop_front() : 8'hFF;
            spi_ack = spi_req;
        end
    end

    // RAM model with write scoreboard.
    always @(negedge clk) begin
        if (!reset && ram_req != ram_ack) begin
            ram_reqs++;
            if (ram_we) begin
                mem[ram_a] = ram_d;
                if (exp_ram.size() > 0) begin
                    e_ram = exp_ram.pop_front();
                    checks++;
                    if (ram_a !== e_ram.addr || ram_d !== e_ram.data) begin
                        failures++;
                        $display("FAIL ram_wr got %05h/%02h want %05h/%02h",
                                 ram_a, ram_d, e_ram.addr, e_ram.data);
                    end
                end
            end else begin
                ram_q = mem[ram_a];
            end
            ram_ack = ram_req;
        end
    end

    // Register read monitor.
    always @(posedge clk) rd_seen <= read_strobe & ~reset;
    always @(negedge clk) begin
        if (rd_seen) begin
            checks++;
            if (exp_rd.size() == 0) begin
                failures++;
                $display("FAIL reg_rd unexpected read got %02h", d_q);
            end else begin
                e_rd = exp_rd.pop_front();
                if (d_q !== e_rd.v) begin
                    failures++;
                    $display("FAIL reg_rd a=%h got %02h want %02h", e_rd.ad, d_q, e_rd.v);
                end
            end
        end
    end

    task automatic wr(input logic [3:0] ad, input logic [7:0] v);
        @(negedge clk); a = ad; d_d = v; write_strobe = 1'b1;
        @(negedge clk); write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [3:0] ad, input logic [7:0] ex);
        rd_t r;
        r.ad = ad; r.v = ex;
        exp_rd.push_back(r);
        @(negedge clk); a = ad; read_strobe = 1'b1;
        @(negedge clk); read_strobe = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL %s got %0h want %0h", nm, act, ex);
        end
    endtask

    task automatic wait_sends(input int target, input string nm);
        int n = 0;
        while (spi_sends < target && n < 20000) begin @(negedge clk); n++; end
        checks++;
        if (spi_sends < target) begin
            failures++;
            $display("FAIL %s spi sends %0d want %0d", nm, spi_sends, target);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_rams(input int target, input string nm);
        int n = 0;
        while (ram_reqs < target && n < 20000) begin @(negedge clk); n++; end
        checks++;
        if (ram_reqs < target) begin
            failures++;
            $display("FAIL %s ram reqs %0d want %0d", nm, ram_reqs, target);
        end
    endtask

    task automatic set_ptr(input logic [23:0] p, input logic [7:0] blks);
        wr(4'h5, p[7:0]); wr(4'h6, p[15:8]); wr(4'h7, p[23:16]); wr(4'h4, blks);
    endtask

    initial begin
        int base_s, base_r;
        ramw_t w;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and static registers.
        rd(4'h1, 8'h03); rd(4'h0, 8'hFF); rd(4'h3, 8'h00); rd(4'h4, 8'h00);
        rd(4'h5, 8'h00); rd(4'h2, 8'h14); rd(4'hB, 8'hFF);
        chk("reset_spi_cs", spi_cs, 1); chk("reset_ram_we", ram_we, 1);

        // Read one block: FF,FF,FE, 512 data bytes, CRC 12 34.
        card_q.push_back(8'hFF); card_q.push_back(8'hFF); card_q.push_back(8'hFE);
        for (int i = 0; i < NB; i++) begin
            card_q.push_back(8'(i));
            w.addr = RAB'(24'h001000 + i); w.data = 8'(i); exp_ram.push_back(w);
        end
        card_q.push_back(8'h12); card_q.push_back(8'h34);
        set_ptr(24'h001000, 8'd1);
        rd(4'h4, 8'h01);
        base_s = spi_sends;
        wr(4'h3, 8'h01);
        wait_sends(base_s + 517, "read1");
        chk("read1_ram_drained", exp_ram.size(), 0);
        rd(4'h5, 8'h00); rd(4'h6, 8'h12); rd(4'h7, 8'h00);
        rd(4'h8, 8'h34); rd(4'h9, 8'h12); rd(4'h3, 8'h00); rd(4'h4, 8'h00);
        chk("read1_ram_1100", mem[17'h1100], 8'h00);
        chk("read1_ram_11ff", mem[17'h11FF], 8'hFF);

        // Token error.
        card_q.push_back(8'hFF); card_q.push_back(8'h0D);
        set_ptr(24'h001000, 8'd1);
        base_s = spi_sends; base_r = ram_reqs;
        wr(4'h3, 8'h01);
        wait_sends(base_s + 2, "tokerr");
        rd(4'h3, 8'h04);
        chk("tokerr_no_ram", ram_reqs - base_r, 0);

        // Timeout: card idles at FF.
        base_s = spi_sends;
        wr(4'h3, 8'h01);
        wait_sends(base_s + PL, "timeout");
        rd(4'h3, 8'h14);
        chk("timeout_polls", spi_sends - base_s, PL);

        // Write two blocks, response E5 each.
        for (int i = 0; i < 2 * NB; i++) mem[RAB'(24'h002000 + i)] = 8'(i * 7 + 3);
        for (int b = 0; b < 2; b++) begin
            exp_spi.push_back(8'hFF); exp_spi.push_back(8'hFE);
            for (int i = 0; i < NB; i++) exp_spi.push_back(8'((b * NB + i) * 7 + 3));
            for (int i = 0; i < 7; i++) exp_spi.push_back(8'hFF);
            for (int i = 0; i < NB + 4; i++) card_q.push_back(8'hFF);
            card_q.push_back(8'hE5);
            for (int i = 0; i < 3; i++) card_q.push_back(8'h00);
            card_q.push_back(8'hFF);
        end
        set_ptr(24'h002000, 8'd2);
        base_s = spi_sends;
        wr(4'h3, 8'h02);
        wait_sends(base_s + 2 * (NB + 9), "write2");
        chk("write2_spi_drained", exp_spi.size(), 0);
        rd(4'hA, 8'hE5); rd(4'h5, 8'h00); rd(4'h6, 8'h24); rd(4'h7, 8'h00);
        rd(4'h4, 8'h00); rd(4'h3, 8'h00);

        // Write two blocks, EB data-response on block 2.
        for (int i = 0; i < NB + 4; i++) card_q.push_back(8'hFF);
        card_q.push_back(8'hE5);
        for (int i = 0; i < 3; i++) card_q.push_back(8'h00);
        card_q.push_back(8'hFF);
        for (int i = 0; i < NB + 4; i++) card_q.push_back(8'hFF);
        card_q.push_back(8'hEB);
        set_ptr(24'h002000, 8'd2);
        base_s = spi_sends;
        wr(4'h3, 8'h02);
        wait_sends(base_s + (NB + 9) + (NB + 5), "write_eb");
        rd(4'h3, 8'h08); rd(4'hA, 8'hEB); rd(4'h4, 8'h01); rd(4'h6, 8'h24);

        // Abort during the data phase of a read.
        card_q.push_back(8'hFE);
        for (int i = 0; i < 600; i++) card_q.push_back(8'(i));
        set_ptr(24'h003000, 8'd1);
        base_r = ram_reqs;
        wr(4'h3, 8'h01);
        wait_rams(base_r + 5, "abort_start");
        wr(4'h3, 8'h00);
        base_s = spi_sends;
        rd(4'h3, 8'h04);
        repeat (20) @(negedge clk);
        chk("abort_spi_quiet", spi_sends - base_s, 0);
        card_q.delete();

        // Reset in the middle of a block write.
        wr(4'h1, 8'h24);
        rd(4'h1, 8'h25);
        for (int i = 0; i < 2000; i++) card_q.push_back(8'hFF);
        set_ptr(24'h004000, 8'd1);
        base_r = ram_reqs;
        wr(4'h3, 8'h02);
        wait_rams(base_r + 10, "rst_start");
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("rst_d_q", d_q, 8'hFF); chk("rst_spi_d", spi_d, 8'hFF);
        chk("rst_cs", spi_cs, 1); chk("rst_speed", spi_speed, 0);
        chk("rst_exdis", disable_exrom, 0); chk("rst_ram_a", ram_a, 0);
        chk("rst_ram_we", ram_we, 1);
        chk("rst_spi_hs", spi_req ^ spi_ack, 0); chk("rst_ram_hs", ram_req ^ ram_ack, 0);
        base_s = spi_sends; base_r = ram_reqs;
        repeat (20) @(negedge clk);
        chk("rst_spi_quiet", spi_sends - base_s, 0);
        chk("rst_ram_quiet", ram_reqs - base_r, 0);
        rd(4'h3, 8'h00);
        card_q.delete();

        // Manual mode: trigger=1 auto-sends FF on each reg-0 read.
        wr(4'h1, 8'h40);
        rd(4'h1, 8'h41);
        card_q.push_back(8'hA5); card_q.push_back(8'h3C);
        exp_spi.push_back(8'hFF); exp_spi.push_back(8'hFF);
        base_s = spi_sends;
        rd(4'h0, 8'hFF);
        rd(4'h0, 8'hA5);
        repeat (4) @(negedge clk);
        rd(4'h0, 8'h3C);
        repeat (4) @(negedge clk);
        chk("manual_auto_sends", spi_sends - base_s, 3);
        exp_spi.delete();
        wr(4'h1, 8'h00);
        exp_spi.push_back(8'h9C);
        base_s = spi_sends;
        wr(4'h0, 8'h9C);
        repeat (4) @(negedge clk);
        chk("manual_tx_send", spi_sends - base_s, 1);
        chk("manual_spi_drained", exp_spi.size(), 0);

        // Pointer wrap FFFFFF -> 000000 during a block read.
        card_q.push_back(8'hFE);
        for (int i = 0; i < NB; i++) begin
            card_q.push_back(8'(i ^ 8'hA5));
            w.addr = RAB'(24'hFFFFFF + i); w.data = 8'(i ^ 8'hA5); exp_ram.push_back(w);
        end
        card_q.push_back(8'hAB); card_q.push_back(8'hCD);
        set_ptr(24'hFFFFFF, 8'd1);
        base_s = spi_sends;
        wr(4'h3, 8'h01);
        wait_sends(base_s + NB + 3, "wrap");
        chk("wrap_ram_drained", exp_ram.size(), 0);
        rd(4'h5, 8'hFF); rd(4'h6, 8'h01); rd(4'h7, 8'h00);
        rd(4'h8, 8'hCD); rd(4'h9, 8'hAB); rd(4'h3, 8'h00);

        repeat (4) @(negedge clk);
        chk("reads_drained", exp_rd.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
